// File: rtl/pulse_tally_pkg.sv
// pulse_tally_pkg: shared FSM state encoding and default sizing for the pulse tally block
package pulse_tally_pkg;
   localparam int PT_CNT_W       = 8;
   localparam int PT_SYNC_STAGES = 2;
   typedef enum logic [1:0] {
      PT_IDLE  = 2'd0,
      PT_SHIFT = 2'd1,
      PT_DONE  = 2'd2
   } pt_state_e;
endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: brings an async line into clk domain and flags its rising edges
module sync_edge_detect #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic rise
);
   logic [STAGES-1:0] r_sync;
   logic              r_sync_d;

   // synchronizer chain plus one-cycle delayed copy of its output
   always_ff @(posedge clk)
      if (rst) begin
         r_sync   <= '0;
         r_sync_d <= 1'b0;
      end else begin
         r_sync   <= {r_sync[STAGES-2:0], d};
         r_sync_d <= r_sync[STAGES-1];
      end

   assign rise = r_sync[STAGES-1] & ~r_sync_d;
endmodule

// File: rtl/pulse_tally.sv
// pulse_tally: saturating edge tally with a sticky overflow and an MSB-first serial snapshot port
module pulse_tally
   import pulse_tally_pkg::*;
#(
   parameter int CNT_W       = PT_CNT_W,
   parameter int SYNC_STAGES = PT_SYNC_STAGES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pulse_in,
   input  logic             clear,
   input  logic             snap_req,
   output logic [CNT_W-1:0] count,
   output logic             overflow,
   output logic             busy,
   output logic             ser_valid,
   output logic             ser_out,
   output logic             done
);
   localparam int BW = $clog2(CNT_W);

   logic             w_rise;
   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] r_shift;
   logic [BW-1:0]    r_bits;
   logic             r_overflow;
   pt_state_e        r_state;

   sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync (
      .clk  (clk),
      .rst  (rst),
      .d    (pulse_in),
      .rise (w_rise)
   );

   // saturating tally; a clear in the same cycle as an edge wins and the edge is dropped
   always_ff @(posedge clk)
      if (rst || clear) begin
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else if (w_rise) begin
         if (&r_count) r_overflow <= 1'b1;
         else          r_count    <= r_count + CNT_W'(1);
      end

   // snapshot/serialize FSM; the shift register is isolated from later count changes
   always_ff @(posedge clk)
      if (rst) begin
         r_state <= PT_IDLE;
         r_shift <= '0;
         r_bits  <= '0;
      end else begin
         case (r_state)
            PT_IDLE:
               if (snap_req) begin
                  r_state <= PT_SHIFT;
                  r_shift <= r_count;
                  r_bits  <= BW'(CNT_W - 1);
               end
            PT_SHIFT: begin
               r_shift <= r_shift << 1;
               r_bits  <= r_bits - BW'(1);
               if (r_bits == '0) r_state <= PT_DONE;
            end
            default: r_state <= PT_IDLE;
         endcase
      end

   assign count     = r_count;
   assign overflow  = r_overflow;
   assign busy      = r_state != PT_IDLE;
   assign ser_valid = r_state == PT_SHIFT;
   assign ser_out   = ser_valid & r_shift[CNT_W-1];
   assign done      = r_state == PT_DONE;
endmodule

// File: tb/tb_pulse_tally.sv
// tb_pulse_tally: vector table for tally/saturation plus scoreboarded serial snapshots
module tb_pulse_tally;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       pulse_in = 1'b0;
   logic       clear = 1'b0;
   logic       snap_req = 1'b0;
   logic [7:0] count;
   logic       overflow, busy, ser_valid, ser_out, done;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   int n_done = 0;
   int nb = 0;
   int blen = 0;
   logic prev_busy = 1'b0;
   logic [7:0] sh = '0;
   logic [7:0] exp_q[$];
   int starts[$];

   typedef struct {
      bit         clr;
      int         pulses;
      int         hi;
      int         lo;
      logic [7:0] exp_cnt;
      logic       exp_ovf;
   } vec_t;
   vec_t vecs[7];

   pulse_tally #(.CNT_W(8), .SYNC_STAGES(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .pulse_in  (pulse_in),
      .clear     (clear),
      .snap_req  (snap_req),
      .count     (count),
      .overflow  (overflow),
      .busy      (busy),
      .ser_valid (ser_valid),
      .ser_out   (ser_out),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, got, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse(input int hi, input int lo);
      pulse_in = 1'b1;
      tick(hi);
      pulse_in = 1'b0;
      tick(lo);
   endtask

   // monitor: collects serial bits, pops expected snapshots on done, measures busy length
   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         nb   = 0;
         blen = 0;
      end else begin
         if (!ser_valid && ser_out) check("ser_out_idle", ser_out, 1'b0);
         if (ser_valid) begin
            sh = {sh[6:0], ser_out};
            nb++;
         end
         if (busy && !prev_busy) starts.push_back(cyc);
         if (busy) blen++;
         else if (blen != 0) begin
            check("busy_len", blen, 9);
            blen = 0;
         end
         if (done) begin
            n_done++;
            if (exp_q.size() == 0) check("done_unexpected", done, 1'b0);
            else begin
               check("snap_bits", sh, exp_q.pop_front());
               check("snap_nbits", nb, 8);
            end
            nb = 0;
         end
      end
      prev_busy = busy;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int d0;
      int s0;
      vecs[0] = '{1'b1, 10, 1, 1, 8'd10,  1'b0};
      vecs[1] = '{1'b0, 5,  3, 1, 8'd15,  1'b0};
      vecs[2] = '{1'b1, 0,  1, 1, 8'd0,   1'b0};
      vecs[3] = '{1'b1, 255,1, 1, 8'd255, 1'b0};
      vecs[4] = '{1'b0, 1,  2, 2, 8'd255, 1'b1};
      vecs[5] = '{1'b1, 257,1, 1, 8'd255, 1'b1};
      vecs[6] = '{1'b0, 2,  2, 2, 8'd255, 1'b1};

      // reset held with a toggling pulse line
      for (int i = 0; i < 6; i++) begin
         @(posedge clk or negedge clk);
         pulse_in = ~pulse_in;
      end
      @(negedge clk);
      check("rst_outs", {count, overflow, busy, ser_valid, ser_out, done}, '0);
      pulse_in = 1'b0;
      tick(1);
      rst = 1'b0;
      tick(2);

      // first pulse with exact latency: first sampled high at edge k, count=1 after k+2
      pulse_in = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("lat_k", count, 0);
      @(posedge clk);
      #1 pulse_in = 1'b0;
      @(negedge clk);
      check("lat_k1", count, 0);
      @(posedge clk);
      @(negedge clk);
      check("lat_k2", count, 1);
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) pulse(2, 2);
      tick(3);
      check("five_pulses", count, 5);

      // table-driven tally vectors
      for (int v = 0; v < 7; v++) begin
         if (vecs[v].clr) begin
            tick(3);
            clear = 1'b1;
            tick(1);
            clear = 1'b0;
         end
         for (int p = 0; p < vecs[v].pulses; p++) pulse(vecs[v].hi, vecs[v].lo);
         tick(4);
         @(negedge clk);
         check($sformatf("vec%0d_count", v), count, vecs[v].exp_cnt);
         check($sformatf("vec%0d_ovf", v), overflow, vecs[v].exp_ovf);
      end

      // clear coincident with a detected edge: both cleared and the edge is lost
      tick(1);
      pulse_in = 1'b1;
      tick(2);
      clear = 1'b1;
      tick(1);
      clear = 1'b0;
      pulse_in = 1'b0;
      @(negedge clk);
      check("clr_edge_count", count, 0);
      check("clr_edge_ovf", overflow, 0);
      tick(4);
      check("clr_edge_lost", count, 0);

      // serialize 8'hA5
      for (int p = 0; p < 165; p++) pulse(1, 1);
      tick(4);
      check("pre_snap_count", count, 8'hA5);
      exp_q.push_back(8'hA5);
      snap_req = 1'b1;
      @(posedge clk);
      #1 snap_req = 1'b0;
      @(negedge clk);
      check("snap_first", {busy, ser_valid, ser_out}, 3'b111);
      repeat (7) @(posedge clk);
      @(negedge clk);
      check("snap_last_bit", {ser_valid, ser_out, done}, 3'b110);
      @(posedge clk);
      @(negedge clk);
      check("snap_done", {busy, ser_valid, done}, 3'b101);
      @(posedge clk);
      @(negedge clk);
      check("snap_idle", {busy, done}, 2'b00);
      tick(2);

      // snap_req held while pulses arrive: snapshots A5 then A7, 10 cycles apart
      starts.delete();
      d0 = n_done;
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'hA7);
      fork
         begin
            snap_req = 1'b1;
            repeat (11) @(posedge clk);
            #1 snap_req = 1'b0;
         end
         for (int p = 0; p < 6; p++) pulse(2, 2);
      join
      tick(12);
      check("b2b_transfers", starts.size(), 2);
      if (starts.size() == 2) check("b2b_period", starts[1] - starts[0], 10);
      check("b2b_dones", n_done - d0, 2);
      check("b2b_count", count, 8'hAB);

      // reset during bit 3 aborts with no done
      d0 = n_done;
      snap_req = 1'b1;
      tick(1);
      snap_req = 1'b0;
      tick(3);
      rst = 1'b1;
      tick(1);
      @(negedge clk);
      check("abort_outs", {count, busy, ser_valid, ser_out, done}, '0);
      rst = 1'b0;
      tick(12);
      check("abort_no_done", n_done - d0, 0);
      check("queue_empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
